ov5640_sccb_slave: RTL and testbench

OV5640_SCCB_SLAVE -- requirements
Module: ov5640_sccb_slave

---
 rtl/ov5640_sccb_slave.sv | 206 ++++++++++++++++++++
 tb/tb_ov5640_sccb_slave.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov5640_sccb_slave.sv
// SCCB (I2C-style) register-access slave for the OV5640 camera model.
// SCL/SDA are oversampled on clk_25M; bus writes become single-cycle strobes.
module ov5640_sccb_slave #(
    parameter logic [6:0] DEV_ADDR    = 7'h3C,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk_25M,
    input  logic        camera_rstn,
    input  logic        i2c_sclk,
    inout  wire         i2c_sdat,
    output logic        wr_valid,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        busy,
    output logic [8:0]  wr_count
);

    typedef enum logic [3:0] {
        IDLE, DEVADDR, ACK_DEV, ADDR_H, ACK_AH, ADDR_L, ACK_AL,
        WDATA, ACK_WD, RDATA, MACK, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;

    state_t      state;
    logic [7:0]  shift_reg;
    logic [7:0]  rx_byte;
    logic [3:0]  bit_cnt;
    logic        rw_bit;
    logic        sda_oe;
    logic [15:0] pointer;

    always_ff @(posedge clk_25M or negedge camera_rstn) begin
        if (!camera_rstn) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync[0] <= i2c_sclk;
            sda_sync[0] <= i2c_sdat;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                scl_sync[i] <= scl_sync[i-1];
                sda_sync[i] <= sda_sync[i-1];
            end
            scl_d <= scl_sync[SYNC_STAGES-1];
            sda_d <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign rx_byte   = {shift_reg[6:0], sda_s};

    function automatic state_t ack_state(input state_t s);
        case (s)
            DEVADDR: return ACK_DEV;
            ADDR_H:  return ACK_AH;
            ADDR_L:  return ACK_AL;
            default: return ACK_WD;
        endcase
    endfunction

    // Byte actions fire on the 8th SCL rise; the ACK slot opens on the following fall.
    always_ff @(posedge clk_25M or negedge camera_rstn) begin
        if (!camera_rstn) begin
            state     <= IDLE;
            shift_reg <= 8'h00;
            bit_cnt   <= 4'd0;
            rw_bit    <= 1'b0;
            sda_oe    <= 1'b0;
            pointer   <= 16'h0000;
            wr_valid  <= 1'b0;
            wr_addr   <= 16'h0000;
            wr_data   <= 8'h00;
            busy      <= 1'b0;
            wr_count  <= 9'd0;
        end else begin
            wr_valid <= 1'b0;
            if (start_det) begin
                state   <= DEVADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b1;
            end else if (stop_det) begin
                state   <= IDLE;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    DEVADDR, ADDR_H, ADDR_L, WDATA: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shift_reg <= rx_byte;
                            bit_cnt   <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                case (state)
                                    DEVADDR: begin
                                        rw_bit <= rx_byte[0];
                                        if (rx_byte[7:1] != DEV_ADDR)
                                            state <= IGNORE;
                                    end
                                    ADDR_H: pointer[15:8] <= rx_byte;
                                    ADDR_L: pointer[7:0]  <= rx_byte;
                                    WDATA: begin
                                        wr_valid <= 1'b1;
                                        wr_addr  <= pointer;
                                        wr_data  <= rx_byte;
                                        if (wr_count != 9'h1FF)
                                            wr_count <= wr_count + 9'd1;
                                    end
                                    default: ;
                                endcase
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_oe <= 1'b1;
                            state  <= ack_state(state);
                        end
                    end
                    ACK_DEV: begin
                        if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            if (rw_bit) begin
                                state     <= RDATA;
                                shift_reg <= rd_data;
                                sda_oe    <= ~rd_data[7];
                            end else begin
                                state  <= ADDR_H;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    ACK_AH: begin
                        if (scl_fall) begin
                            state   <= ADDR_L;
                            bit_cnt <= 4'd0;
                            sda_oe  <= 1'b0;
                        end
                    end
                    ACK_AL: begin
                        if (scl_fall) begin
                            state   <= WDATA;
                            bit_cnt <= 4'd0;
                            sda_oe  <= 1'b0;
                        end
                    end
                    ACK_WD: begin
                        if (scl_fall) begin
                            state   <= WDATA;
                            bit_cnt <= 4'd0;
                            sda_oe  <= 1'b0;
                            pointer <= pointer + 16'd1;
                        end
                    end
                    RDATA: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                state  <= MACK;
                            end else begin
                                sda_oe    <= ~shift_reg[6];
                                shift_reg <= {shift_reg[6:0], 1'b0};
                            end
                        end
                    end
                    // The pointer moves on the ACK rise so rd_data has settled by the next fall.
                    MACK: begin
                        if (scl_rise) begin
                            if (sda_s)
                                state <= IGNORE;
                            else
                                pointer <= pointer + 16'd1;
                        end else if (scl_fall) begin
                            state     <= RDATA;
                            bit_cnt   <= 4'd0;
                            shift_reg <= rd_data;
                            sda_oe    <= ~rd_data[7];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign i2c_sdat = sda_oe ? 1'b0 : 1'bz;
    assign rd_addr  = pointer;

endmodule

// File: tb/tb_ov5640_sccb_slave.sv
// Bench for ov5640_sccb_slave: bit-banged SCCB master, transaction-level model
// of pointer/register/count behaviour, and a queue-based write-strobe scoreboard.
module tb_ov5640_sccb_slave;

    localparam logic [6:0] DEV = 7'h3C;
    localparam int Q = 5;
    localparam int H = 10;

    logic        clk_25M     = 1'b0;
    logic        camera_rstn = 1'b0;
    logic        scl         = 1'b1;
    logic        master_low  = 1'b0;
    wire         sda_bus;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data = 8'h00;
    logic        busy;
    logic [8:0]  wr_count;

    assign sda_bus = master_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #20 clk_25M = ~clk_25M;

    ov5640_sccb_slave #(.DEV_ADDR(DEV), .SYNC_STAGES(2)) dut (
        .clk_25M    (clk_25M),
        .camera_rstn(camera_rstn),
        .i2c_sclk   (scl),
        .i2c_sdat   (sda_bus),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .wr_count   (wr_count)
    );

    int n_checks = 0;
    int n_fails  = 0;

    logic [23:0] exp_q[$];
    logic [7:0]  model_mem [logic [15:0]];
    logic [15:0] m_ptr   = 16'h0000;
    int          m_count = 0;
    logic [7:0]  wbuf [0:7];

    logic [7:0]  dev_mem [0:65535] = '{default: 8'h00};
    bit          dev_wr  [0:65535] = '{default: 1'b0};
    logic [7:0]  rd_pipe = 8'h00;
    logic        prev_valid = 1'b0;
    logic [23:0] exp_e;
    int          dut_low_cnt = 0;

    // Power-up contents of the camera register file.
    function automatic logic [7:0] init_pat(input logic [15:0] a);
        if (a == 16'h300A) return 8'h56;
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] model_read(input logic [15:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return init_pat(a);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Camera register file: two-cycle lookup latency, updated by the slave's strobes.
    always @(posedge clk_25M) begin
        rd_pipe <= dev_wr[rd_addr] ? dev_mem[rd_addr] : init_pat(rd_addr);
        rd_data <= rd_pipe;
        if (camera_rstn && wr_valid) begin
            dev_mem[wr_addr] <= wr_data;
            dev_wr[wr_addr]  <= 1'b1;
        end
    end

    // Counts cycles where SDA is low while the master is not pulling it.
    always @(posedge clk_25M) begin
        if (!master_low && sda_bus === 1'b0)
            dut_low_cnt <= dut_low_cnt + 1;
    end

    always @(negedge clk_25M) begin
        if (camera_rstn && wr_valid) begin
            checkOutput("wr_valid_single_cycle", {31'd0, prev_valid}, 0);
            checkOutput("strobe_expected", {31'd0, exp_q.size() != 0}, 1);
            if (exp_q.size() != 0) begin
                exp_e = exp_q.pop_front();
                checkOutput("strobe_wr_addr", {16'd0, wr_addr}, {16'd0, exp_e[23:8]});
                checkOutput("strobe_wr_data", {24'd0, wr_data}, {24'd0, exp_e[7:0]});
            end
        end
        prev_valid <= wr_valid;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_25M);
    endtask

    task automatic bus_start();
        wait_cyc(Q); master_low = 1'b0;
        wait_cyc(Q); scl = 1'b1;
        wait_cyc(H); master_low = 1'b1;
        wait_cyc(H); scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_cyc(Q); master_low = 1'b1;
        wait_cyc(Q); scl = 1'b1;
        wait_cyc(H); master_low = 1'b0;
        wait_cyc(H);
    endtask

    task automatic bit_clk(input bit drive_low, output bit sampled);
        wait_cyc(Q); master_low = drive_low;
        wait_cyc(Q); scl = 1'b1;
        wait_cyc(H / 2); sampled = sda_bus;
        wait_cyc(H / 2); scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ack);
        bit s;
        for (int i = 7; i >= 0; i--) bit_clk(!b[i], s);
        bit_clk(1'b0, ack);
    endtask

    task automatic read_byte(input bit nack, output logic [7:0] b);
        bit s;
        for (int i = 7; i >= 0; i--) begin
            bit_clk(1'b0, s);
            b[i] = s;
        end
        bit_clk(!nack, s);
    endtask

    task automatic applyStimulus(input logic [7:0] dev, input int nw, input int nr, input bit with_stop);
        bit         ack;
        bit         match;
        logic [7:0] got;
        logic [7:0] expv;
        int         snap;
        match = (dev[7:1] == DEV);
        snap  = dut_low_cnt;
        bus_start();
        checkOutput("busy_after_start", {31'd0, busy}, 1);
        send_byte(dev, ack);
        checkOutput("ack_devaddr", {31'd0, ack}, {31'd0, !match});
        if (!match) begin
            for (int i = 0; i < nw; i++) begin
                send_byte(wbuf[i], ack);
                checkOutput("no_ack_foreign_byte", {31'd0, ack}, 1);
            end
            checkOutput("busy_while_ignoring", {31'd0, busy}, 1);
            checkOutput("sda_never_low_foreign", dut_low_cnt - snap, 0);
        end else if (!dev[0]) begin
            for (int i = 0; i < nw; i++) begin
                if (i == 0) m_ptr[15:8] = wbuf[0];
                else if (i == 1) m_ptr[7:0] = wbuf[1];
                else begin
                    exp_q.push_back({m_ptr, wbuf[i]});
                    model_mem[m_ptr] = wbuf[i];
                    if (m_count < 511) m_count++;
                    m_ptr = m_ptr + 16'd1;
                end
                send_byte(wbuf[i], ack);
                checkOutput("ack_write_byte", {31'd0, ack}, 0);
            end
        end else begin
            for (int i = 0; i < nr; i++) begin
                expv = model_read(m_ptr);
                read_byte(i == nr - 1, got);
                checkOutput("read_byte", {24'd0, got}, {24'd0, expv});
                if (i != nr - 1) m_ptr = m_ptr + 16'd1;
            end
        end
        if (with_stop) begin
            bus_stop();
            checkOutput("busy_after_stop", {31'd0, busy}, 0);
            checkOutput("wr_count", {23'd0, wr_count}, m_count);
            checkOutput("rd_addr", {16'd0, rd_addr}, {16'd0, m_ptr});
        end
    endtask

    initial begin
        #3800000;
        $display("[TB] FAIL watchdog: run did not complete in time");
        $fatal(1);
    end

    initial begin
        bit         ack;
        bit         s;
        int         kind;
        int         nd;
        int         snap;
        logic [15:0] ptr;
        logic [7:0]  dv;

        wait_cyc(3);
        checkOutput("reset_wr_valid", {31'd0, wr_valid}, 0);
        checkOutput("reset_wr_addr", {16'd0, wr_addr}, 0);
        checkOutput("reset_wr_data", {24'd0, wr_data}, 0);
        checkOutput("reset_rd_addr", {16'd0, rd_addr}, 0);
        checkOutput("reset_busy", {31'd0, busy}, 0);
        checkOutput("reset_wr_count", {23'd0, wr_count}, 0);
        checkOutput("reset_sda", {31'd0, sda_bus}, 1);
        camera_rstn = 1'b1;
        wait_cyc(5);

        $display("[TB] single register write");
        wbuf[0] = 8'h31; wbuf[1] = 8'h03; wbuf[2] = 8'h11;
        applyStimulus(8'h78, 3, 0, 1);

        $display("[TB] foreign device address");
        wbuf[0] = 8'h31; wbuf[1] = 8'h03; wbuf[2] = 8'h22;
        applyStimulus(8'h7A, 3, 0, 1);

        $display("[TB] sequential write");
        wbuf[0] = 8'h30; wbuf[1] = 8'h08; wbuf[2] = 8'h82; wbuf[3] = 8'h42;
        applyStimulus(8'h78, 4, 0, 1);

        $display("[TB] pointer wrap");
        wbuf[0] = 8'hFF; wbuf[1] = 8'hFF; wbuf[2] = 8'hAA; wbuf[3] = 8'hBB;
        applyStimulus(8'h78, 4, 0, 1);

        $display("[TB] pointer set, repeated start, read");
        wbuf[0] = 8'h30; wbuf[1] = 8'h0A;
        applyStimulus(8'h78, 2, 0, 0);
        applyStimulus(8'h79, 0, 1, 1);

        $display("[TB] stop inside a data byte");
        bus_start();
        send_byte(8'h78, ack); checkOutput("partial_ack_dev", {31'd0, ack}, 0);
        send_byte(8'h30, ack); checkOutput("partial_ack_ah", {31'd0, ack}, 0);
        send_byte(8'h10, ack); checkOutput("partial_ack_al", {31'd0, ack}, 0);
        m_ptr = 16'h3010;
        for (int i = 0; i < 4; i++) bit_clk(1'($urandom_range(0, 1)), s);
        bus_stop();
        checkOutput("partial_busy", {31'd0, busy}, 0);
        checkOutput("partial_wr_count", {23'd0, wr_count}, m_count);
        checkOutput("partial_rd_addr", {16'd0, rd_addr}, {16'd0, m_ptr});
        wbuf[0] = 8'h30; wbuf[1] = 8'h10; wbuf[2] = 8'h5A;
        applyStimulus(8'h78, 3, 0, 1);

        $display("[TB] reset during an acknowledge");
        bus_start();
        send_byte(8'h78, ack);
        send_byte(8'h31, ack);
        for (int i = 7; i >= 0; i--) bit_clk(i == 0 || i == 1, s);
        wait_cyc(Q); master_low = 1'b0;
        wait_cyc(2);
        checkOutput("ack_low_before_reset", {31'd0, sda_bus}, 0);
        camera_rstn = 1'b0;
        wait_cyc(1);
        checkOutput("midreset_sda", {31'd0, sda_bus}, 1);
        checkOutput("midreset_wr_valid", {31'd0, wr_valid}, 0);
        checkOutput("midreset_wr_addr", {16'd0, wr_addr}, 0);
        checkOutput("midreset_wr_data", {24'd0, wr_data}, 0);
        checkOutput("midreset_rd_addr", {16'd0, rd_addr}, 0);
        checkOutput("midreset_busy", {31'd0, busy}, 0);
        checkOutput("midreset_wr_count", {23'd0, wr_count}, 0);
        m_ptr = 16'h0000;
        m_count = 0;
        wait_cyc(2);
        camera_rstn = 1'b1;
        wait_cyc(Q); scl = 1'b1;
        wait_cyc(H); scl = 1'b0;
        snap = dut_low_cnt;
        send_byte(8'h11, ack);
        checkOutput("post_reset_no_ack", {31'd0, ack}, 1);
        checkOutput("post_reset_sda_quiet", dut_low_cnt - snap, 0);
        bus_stop();
        checkOutput("post_reset_wr_count", {23'd0, wr_count}, 0);
        checkOutput("post_reset_rd_addr", {16'd0, rd_addr}, 0);

        $display("[TB] randomized transactions");
        for (int t = 0; t < 16; t++) begin
            kind = $urandom_range(0, 3);
            nd   = $urandom_range(1, 3);
            ptr  = (t % 5 == 0) ? 16'hFFFE : {8'h30, 8'($urandom_range(0, 15))};
            wbuf[0] = ptr[15:8];
            wbuf[1] = ptr[7:0];
            for (int i = 2; i < 8; i++) wbuf[i] = 8'($urandom);
            case (kind)
                0, 1: applyStimulus(8'h78, 2 + nd, 0, 1);
                2: begin
                    applyStimulus(8'h78, 2, 0, 0);
                    applyStimulus(8'h79, 0, nd, 1);
                end
                default: begin
                    dv = 8'($urandom);
                    if (dv[7:1] == DEV) dv[7:1] = dv[7:1] ^ 7'h01;
                    applyStimulus(dv, 3, 0, 1);
                end
            endcase
        end

        wait_cyc(5);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
